seq_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider. An FSM drives one shared shift/subtract datapath
//  and produces one quotient bit per clock, MSB first.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 121 ++++++++++++
 tb/tb_seq_divider.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: start/ready handshake in, done pulse and held results out.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// sharing a single shift/subtract datapath under a small FSM.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for start; results held; ready=1
//  S_RUN    | WIDTH shift/subtract steps, one quotient bit per edge
//  S_ZERO   | divisor was 0; load saturated quotient and flag next edge
//  S_FINISH | done=1 for this cycle only; ready=1, may accept back-to-back
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             sub_ok;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
    end
  end

  // Partial remainder carries one extra bit so the compare never overflows.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    sub_ok  = (shifted >= {1'b0, dsr_q});
    accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_FINISH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        rem_d = sub_ok ? diff : shifted;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d = {quo_q[WIDTH-2:0], sub_ok};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FINISH;
          q_out_d = quo_d;
          r_out_d = rem_d[WIDTH-1:0];
        end
      end
      S_ZERO: begin
        state_d = S_FINISH;
        q_out_d = '1;
        r_out_d = dvd_q;
        dz_d    = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Accept overrides the FINISH->IDLE step so back-to-back requests lose no cycle.
    if (accept) begin
      dvd_d   = bus.dividend;
      dsr_d   = bus.divisor;
      rem_d   = '0;
      quo_d   = '0;
      cnt_d   = '0;
      q_out_d = '0;
      r_out_d = '0;
      dz_d    = 1'b0;
      state_d = (bus.divisor != '0) ? S_RUN : S_ZERO;
    end
  end

  assign bus.ready       = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign bus.done        = (state_q == S_FINISH);
  assign bus.quotient    = q_out_q;
  assign bus.remainder   = r_out_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed scenarios, random ops and a full sweep
// compared against plain / and % arithmetic.
module tb_seq_divider;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1; lat = 2;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = W + 1;
    end
  endfunction

  // Drives one request and waits (bounded) for done; lat counts edges from the accept edge as 1.
  task automatic do_op(input int a, input int b, output int q, output int r,
                       output int dz, output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 8'(b);
    @(posedge clk);
    #1;
    lat          = 1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = int'(bus.quotient);
    r  = int'(bus.remainder);
    dz = int'(bus.div_by_zero);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset = 1'b1;
    #12;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd0 ||
        bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b q=%0d r=%0d dz=%b, required ready=1 done=0 q=0 r=0 dz=0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b done=%b, required ready=1 done=0", bus.ready, bus.done);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dividend = 8'hAA; bus.divisor = 8'h55;
    for (int e = 1; e <= 8; e++) begin
      checks++;
      if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL busy_edge%0d: ready=%b done=%b, required ready=0 done=0", e, bus.ready, bus.done);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.quotient !== 8'd100 ||
        bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL 200div2_edge9: done=%b ready=%b q=%0d r=%0d dz=%b, required done=1 ready=1 q=100 r=0 dz=0",
               bus.done, bus.ready, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 8'd100 || bus.remainder !== 8'd0) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b q=%0d r=%0d, required done=0 q=100 r=0",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_boundaries();
    int tbl[4][4] = '{'{255, 16, 15, 15}, '{7, 9, 0, 7}, '{0, 5, 0, 0}, '{173, 1, 173, 0}};
    int q, r, dz, lat;
    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i][0], tbl[i][1], q, r, dz, lat);
      checks++;
      if (q != tbl[i][2] || r != tbl[i][3] || dz != 0 || lat != W + 1) begin
        errors++;
        $display("FAIL bound_%0ddiv%0d: q=%0d r=%0d dz=%0d lat=%0d, required q=%0d r=%0d dz=0 lat=%0d",
                 tbl[i][0], tbl[i][1], q, r, dz, lat, tbl[i][2], tbl[i][3], W + 1);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int q, r, dz, lat;
    do_op(37, 0, q, r, dz, lat);
    checks++;
    if (q != 255 || r != 37 || dz != 1 || lat != 2) begin
      errors++;
      $display("FAIL div0_37: q=%0d r=%0d dz=%0d lat=%0d, required q=255 r=37 dz=1 lat=2", q, r, dz, lat);
    end
    do_op(10, 3, q, r, dz, lat);
    checks++;
    if (q != 3 || r != 1 || dz != 0 || lat != W + 1) begin
      errors++;
      $display("FAIL after_div0_10div3: q=%0d r=%0d dz=%0d lat=%0d, required q=3 r=1 dz=0 lat=9", q, r, dz, lat);
    end
  endtask

  task automatic test_start_during_run();
    int lat = 1;
    int dones = 0;
    logic [7:0] q2 = '0, r2 = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.dividend = 8'd50; bus.divisor = 8'd6;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != W + 1 || bus.quotient !== 8'd28 || bus.remainder !== 8'd4 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=28 r=4 dz=0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
      errors++;
      $display("FAIL finish_accept_clears: ready=%b q=%0d r=%0d, required ready=0 q=0 r=0",
               bus.ready, bus.quotient, bus.remainder);
    end
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dones++;
        q2 = bus.quotient;
        r2 = bus.remainder;
      end
    end
    checks++;
    if (dones != 1 || q2 !== 8'd8 || r2 !== 8'd2) begin
      errors++;
      $display("FAIL back_to_back_second: dones=%0d q=%0d r=%0d, required dones=1 q=8 r=2", dones, q2, r2);
    end
  endtask

  task automatic test_reset_mid_run();
    int q, r, dz, lat;
    int dones = 0;
    do_op(200, 3, q, r, dz, lat);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_results: q=%0d r=%0d ready=%b, required q=0 r=0 ready=1",
               bus.quotient, bus.remainder, bus.ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 8'd0 ||
        bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: ready=%b done=%b q=%0d r=%0d dz=%b, required ready=1 done=0 q=0 r=0 dz=0",
               bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL aborted_no_done: dones=%0d, required 0", dones);
    end
    do_op(9, 4, q, r, dz, lat);
    checks++;
    if (q != 2 || r != 1 || dz != 0 || lat != W + 1) begin
      errors++;
      $display("FAIL fresh_9div4: q=%0d r=%0d dz=%0d lat=%0d, required q=2 r=1 dz=0 lat=9", q, r, dz, lat);
    end
  endtask

  task automatic test_random();
    int a, b, q, r, dz, lat, eq, er, edz, elat;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(255));
      b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
      repeat ($urandom_range(2)) @(posedge clk);
      do_op(a, b, q, r, dz, lat);
      model(a, b, eq, er, edz, elat);
      checks++;
      if (q != eq || r != er || dz != edz || lat != elat) begin
        errors++;
        $display("FAIL rand_%0ddiv%0d: q=%0d r=%0d dz=%0d lat=%0d, required q=%0d r=%0d dz=%0d lat=%0d",
                 a, b, q, r, dz, lat, eq, er, edz, elat);
      end
    end
  endtask

  task automatic test_sweep();
    int dv[7] = '{0, 1, 2, 3, 7, 128, 255};
    int q, r, dz, lat, eq, er, edz, elat;
    int mism = 0;
    for (int j = 0; j < 7 && mism < 5; j++) begin
      for (int a = 0; a < 256 && mism < 5; a++) begin
        do_op(a, dv[j], q, r, dz, lat);
        model(a, dv[j], eq, er, edz, elat);
        checks++;
        if (q != eq || r != er || dz != edz || lat != elat) begin
          errors++;
          mism++;
          $display("FAIL sweep_%0ddiv%0d: q=%0d r=%0d dz=%0d lat=%0d, required q=%0d r=%0d dz=%0d lat=%0d",
                   a, dv[j], q, r, dz, lat, eq, er, edz, elat);
        end
      end
    end
    if (mism == 0) $display("TEST PASSED.");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_div_by_zero();
    test_start_during_run();
    test_reset_mid_run();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
